// File: rtl/sprite_layer_renderer.sv
// Sprite layer: one ROM sprite at a frame-latched position with 2^scale magnification, colour-key
// transparency and background pass-through. Latency 2+ROM_LATENCY vga_clk; no backpressure. Optional SPRITE_LAYER_MIRROR_EN adds mirror_x.
module sprite_layer_renderer #(
  parameter int SPRITE_W        = 130,
  parameter int SPRITE_H        = 50,
  parameter int ADDR_W          = 13,
  parameter int IDX_W           = 4,
  parameter int ROM_LATENCY     = 1,
  parameter int TRANSPARENT_IDX = 0
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic [1:0]        scale,
  input  logic              layer_en,
`ifdef SPRITE_LAYER_MIRROR_EN
  input  logic              mirror_x,
`endif
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              sprite_hit
);

  localparam int CW = 16;
  localparam int PD = 1 + ROM_LATENCY;
  localparam int PW = 14;

  logic [9:0]        x0_q, x0_d, y0_q, y0_d, prev_y_q, prev_y_d;
  logic [1:0]        sc_q, sc_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, rom_address_q, rom_address_d;
  logic [PD-1:0][PW-1:0] pipe_q, pipe_d;
  logic [3:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic              sprite_hit_q, sprite_hit_d;

  logic              frame_latch, in_x, in_y, row_step;
  logic [CW-1:0]     x_hi, y_hi;
  logic [9:0]        rel_x, rel_y, col_raw, col, row_mask;
  logic              hit_al, blank_al;
  logic [11:0]       bg_al;

`ifdef SPRITE_LAYER_MIRROR_EN
  logic mirror_q, mirror_d;
`endif

  assign frame_latch = (DrawX == 10'd0) && (DrawY == 10'd0);

  // The latch cycle itself already uses the new shadow values and a cleared row base,
  // so pixel (0,0) of the new frame is drawn with the new placement.
  always_comb begin
    x0_d = frame_latch ? sprite_x : x0_q;
    y0_d = frame_latch ? sprite_y : y0_q;
    sc_d = frame_latch ? scale    : sc_q;
    en_d = frame_latch ? layer_en : en_q;
`ifdef SPRITE_LAYER_MIRROR_EN
    mirror_d = frame_latch ? mirror_x : mirror_q;
`endif
  end

  always_comb begin
    x_hi     = CW'(x0_d) + (CW'(SPRITE_W) << sc_d);
    y_hi     = CW'(y0_d) + (CW'(SPRITE_H) << sc_d);
    in_x     = (CW'(DrawX) >= CW'(x0_d)) && (CW'(DrawX) < x_hi);
    in_y     = (CW'(DrawY) >= CW'(y0_d)) && (CW'(DrawY) < y_hi);
    rel_x    = DrawX - x0_d;
    rel_y    = DrawY - y0_d;
    col_raw  = rel_x >> sc_d;
`ifdef SPRITE_LAYER_MIRROR_EN
    col      = mirror_d ? (10'(SPRITE_W - 1) - col_raw) : col_raw;
`else
    col      = col_raw;
`endif
    row_mask = (10'd1 << sc_d) - 10'd1;
    row_step = (DrawY != prev_y_q) && (DrawY > y0_d) && in_y && ((rel_y & row_mask) == 10'd0);
    prev_y_d = DrawY;
    if (frame_latch)
      row_base_d = '0;
    else
      row_base_d = row_base_q + (row_step ? ADDR_W'(SPRITE_W) : '0);
    rom_address_d = (in_x && in_y) ? (row_base_d + ADDR_W'(col)) : '0;
  end

  // Hit (already gated by the frame's enable), blank and bg travel alongside the ROM read.
  assign pipe_d = {pipe_q[PD-2:0], {en_d & in_x & in_y, blank, bg_red, bg_green, bg_blue}};
  assign hit_al   = pipe_q[PD-1][13];
  assign blank_al = pipe_q[PD-1][12];
  assign bg_al    = pipe_q[PD-1][11:0];

  always_comb begin
    red_d        = 4'd0;
    green_d      = 4'd0;
    blue_d       = 4'd0;
    sprite_hit_d = 1'b0;
    if (blank_al) begin
      if (hit_al && (rom_q != IDX_W'(TRANSPARENT_IDX))) begin
        red_d        = pal_red;
        green_d      = pal_green;
        blue_d       = pal_blue;
        sprite_hit_d = 1'b1;
      end else begin
        red_d   = bg_al[11:8];
        green_d = bg_al[7:4];
        blue_d  = bg_al[3:0];
      end
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      x0_q          <= '0;
      y0_q          <= '0;
      sc_q          <= '0;
      en_q          <= 1'b0;
      prev_y_q      <= '0;
      row_base_q    <= '0;
      rom_address_q <= '0;
      pipe_q        <= '0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      sprite_hit_q  <= 1'b0;
`ifdef SPRITE_LAYER_MIRROR_EN
      mirror_q      <= 1'b0;
`endif
    end else begin
      x0_q          <= x0_d;
      y0_q          <= y0_d;
      sc_q          <= sc_d;
      en_q          <= en_d;
      prev_y_q      <= prev_y_d;
      row_base_q    <= row_base_d;
      rom_address_q <= rom_address_d;
      pipe_q        <= pipe_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      sprite_hit_q  <= sprite_hit_d;
`ifdef SPRITE_LAYER_MIRROR_EN
      mirror_q      <= mirror_d;
`endif
    end
  end

  assign rom_address = rom_address_q;
  assign pal_index   = rom_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign sprite_hit  = sprite_hit_q;

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Directed bench for sprite_layer_renderer: ROM[i] = i % 16 with one cycle latency,
// palette red = idx, green = ~idx, blue = idx ^ 5.
module tb_sprite_layer_renderer;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  DrawX, DrawY, sprite_x, sprite_y;
  logic        blank, layer_en, mirror_x;
  logic [1:0]  scale;
  logic [3:0]  bg_red, bg_green, bg_blue;
  logic [12:0] rom_address;
  logic [3:0]  rom_q, pal_index, pal_red, pal_green, pal_blue;
  logic [3:0]  red, green, blue;
  logic        sprite_hit;

  int n_vec = 0;
  int n_bad = 0;

  always #5 vga_clk = ~vga_clk;

  sprite_layer_renderer dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .scale(scale), .layer_en(layer_en),
`ifdef SPRITE_LAYER_MIRROR_EN
    .mirror_x(mirror_x),
`endif
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_address(rom_address), .rom_q(rom_q), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue), .sprite_hit(sprite_hit)
  );

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) rom_q <= 4'd0;
    else       rom_q <= rom_address[3:0];
  end

  assign pal_red   = pal_index;
  assign pal_green = ~pal_index;
  assign pal_blue  = pal_index ^ 4'h5;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int x, input int y, input int n);
    DrawX = 10'(x);
    DrawY = 10'(y);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask

  task automatic chk_addr(input string tag, input int exp);
    chk(tag, 32'(rom_address), 32'(exp));
  endtask

  task automatic chk_rgb(input string tag, input logic [3:0] r, input logic [3:0] g,
                         input logic [3:0] b, input logic h);
    chk({tag, ".r"}, 32'(red), 32'(r));
    chk({tag, ".g"}, 32'(green), 32'(g));
    chk({tag, ".b"}, 32'(blue), 32'(b));
    chk({tag, ".hit"}, 32'(sprite_hit), 32'(h));
  endtask

  task automatic chk_tex(input string tag, input int idx);
    logic [3:0] i;
    i = 4'(idx);
    chk_rgb(tag, i, ~i, i ^ 4'h5, 1'b1);
  endtask

  initial begin
    reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b1;
    sprite_x = '0; sprite_y = '0; scale = '0; layer_en = 1'b0; mirror_x = 1'b0;
    bg_red = 4'hA; bg_green = 4'hA; bg_blue = 4'hA;
    #1;
    chk_addr("rst_addr", 0);
    chk_rgb("rst_rgb", 4'h0, 4'h0, 4'h0, 1'b0);
    repeat (2) @(posedge vga_clk);
    #1 reset = 1'b0;

    // Unscaled sprite at (100,50)
    sprite_x = 10'd100; sprite_y = 10'd50; scale = 2'd0; layer_en = 1'b1;
    drive(0, 0, 1);
    drive(100, 50, 1); chk_addr("u_addr0", 0);
    drive(100, 50, 2); chk_rgb("u_transp", 4'hA, 4'hA, 4'hA, 1'b0);
    drive(105, 50, 1); chk_addr("u_addr5", 5);
    drive(105, 50, 2); chk_tex("u_tex5", 5);
    drive(99, 51, 1);  chk_addr("u_left_out", 0);
    drive(99, 51, 2);  chk_rgb("u_left_bg", 4'hA, 4'hA, 4'hA, 1'b0);
    drive(101, 51, 1); chk_addr("u_addr131", 131);
    drive(101, 51, 1); chk("u_lat_early", 32'(sprite_hit), 32'd0);
    chk("u_pal_index", 32'(pal_index), 32'd3);
    drive(101, 51, 1); chk_tex("u_lat3", 3);
    blank = 1'b0;
    drive(101, 51, 3); chk_rgb("blank", 4'h0, 4'h0, 4'h0, 1'b0);
    blank = 1'b1;

    // Mid-frame move has no effect until the next latch
    sprite_x = 10'd200;
    drive(150, 60, 1); chk_addr("tear_addr", 310);
    drive(150, 60, 2); chk_tex("tear_tex", 6);
    drive(0, 240, 1);
    drive(0, 0, 1);
    drive(150, 50, 3); chk_rgb("moved_old", 4'hA, 4'hA, 4'hA, 1'b0);
    drive(203, 50, 1); chk_addr("moved_addr", 3);
    drive(203, 50, 2); chk_tex("moved_tex", 3);

    // Scale 2 at (0,0)
    sprite_x = 10'd0; sprite_y = 10'd0; scale = 2'd2;
    drive(0, 0, 1); chk_addr("s2_x0", 0);
    drive(3, 0, 1); chk_addr("s2_x3", 0);
    drive(4, 0, 1); chk_addr("s2_x4", 1);
    drive(8, 0, 1); chk_addr("s2_x8", 2);
    for (int y = 1; y < 4; y++) drive(0, y, 1);
    drive(3, 3, 1); chk_addr("s2_y3", 0);
    drive(0, 4, 1); chk_addr("s2_y4", 130);
    drive(5, 4, 1); chk_addr("s2_y4x5", 131);
    for (int y = 5; y < 199; y++) drive(0, y, 1);
    drive(519, 199, 1); chk_addr("s2_last", 6499);
    drive(519, 199, 2); chk_tex("s2_last_tex", 3);
    drive(520, 199, 1); chk_addr("s2_past_x", 0);
    drive(520, 199, 2); chk_rgb("s2_past_x_rgb", 4'hA, 4'hA, 4'hA, 1'b0);
    drive(519, 200, 1); chk_addr("s2_past_y", 0);

    // Right-edge clipping, no wrap to the left
    sprite_x = 10'd600; sprite_y = 10'd100; scale = 2'd0;
    drive(0, 0, 1);
    drive(0, 100, 1);  chk_addr("clip_x0", 0);
    drive(89, 100, 3); chk_rgb("clip_x89", 4'hA, 4'hA, 4'hA, 1'b0);
    drive(599, 100, 1); chk_addr("clip_x599", 0);
    drive(610, 100, 1); chk_addr("clip_x610", 10);
    drive(610, 100, 2); chk_tex("clip_tex10", 10);
    drive(639, 100, 1); chk_addr("clip_x639", 39);
    drive(639, 100, 2); chk_tex("clip_tex39", 7);

    // Scale 3: 1040-wide extent clipped at the screen edge
    sprite_x = 10'd0; sprite_y = 10'd0; scale = 2'd3;
    drive(0, 0, 1);
    drive(639, 0, 1); chk_addr("s3_x639", 79);
    drive(639, 0, 2); chk_tex("s3_tex", 15);

    // Off-screen x0 never hits
    sprite_x = 10'd700; scale = 2'd0;
    drive(0, 0, 1);
    drive(639, 0, 1); chk_addr("off_addr", 0);
    drive(639, 0, 2); chk_rgb("off_rgb", 4'hA, 4'hA, 4'hA, 1'b0);

    // Async reset mid-line
    sprite_x = 10'd100; sprite_y = 10'd50;
    drive(0, 0, 1);
    drive(105, 50, 3); chk_tex("pre_rst", 5);
    #2 reset = 1'b1;
    #1;
    chk_addr("arst_addr", 0);
    chk_rgb("arst_rgb", 4'h0, 4'h0, 4'h0, 1'b0);
    drive(105, 50, 2);
    reset = 1'b0;
    layer_en = 1'b0;
    bg_red = 4'h1; bg_green = 4'h2; bg_blue = 4'h3;
    drive(105, 50, 3); chk_rgb("post_rst_bg", 4'h1, 4'h2, 4'h3, 1'b0);
    drive(0, 0, 1);
    drive(105, 50, 3); chk_rgb("en0_bg", 4'h1, 4'h2, 4'h3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_layer_renderer.md
Name: sprite_layer_renderer

Overview:
- Parametrised successor to the full-screen stretched sprite renderer.
- Draws one SPRITE_W x SPRITE_H ROM sprite at a movable on-screen position with power-of-two integer scaling, colour-key transparency and a background pass-through.
- Multiply- and divide-free addressing: row base accumulator plus column shift.
- Sits between the VGA controller (DrawX/DrawY/blank) and the colour outputs; layers chain by feeding one layer's RGB into the next layer's bg inputs.

Parameters:
- SPRITE_W, 130, sprite width in texels.
- SPRITE_H, 50, sprite height in texels.
- ADDR_W, 13, ROM address width; must satisfy 2^ADDR_W >= SPRITE_W*SPRITE_H.
- IDX_W, 4, palette index width.
- ROM_LATENCY, 1, cycles from rom_address to rom_q, 1..3.
- TRANSPARENT_IDX, 0, palette index treated as transparent.

Ports:
- vga_clk, input, 1, pixel clock.
- reset, input, 1, asynchronous active-high reset.
- DrawX, input, 10, current pixel column.
- DrawY, input, 10, current pixel row.
- blank, input, 1, 1 = visible region.
- sprite_x, input, 10, left edge of sprite, screen pixels.
- sprite_y, input, 10, top edge of sprite, screen pixels.
- scale, input, 2, log2 magnification, 0..3.
- layer_en, input, 1, 0 = always pass background.
- bg_red, bg_green, bg_blue, input, 4 each, background colour for the current pixel.
- rom_address, output, ADDR_W, registered ROM address.
- rom_q, input, IDX_W, ROM data.
- pal_index, output, IDX_W, palette index (equals the aligned rom_q).
- pal_red, pal_green, pal_blue, input, 4 each, combinational palette result.
- red, green, blue, output, 4 each, registered pixel colour.
- sprite_hit, output, 1, registered; 1 when an opaque sprite texel is output.

Behaviour:
- Reset (async): red/green/blue=0; sprite_hit=0; rom_address=0; shadow registers=0; row_base=0; all pipeline stages cleared (blank treated as 0).
- Frame latch:
  - On the cycle DrawX==0 && DrawY==0, sample sprite_x, sprite_y, scale and layer_en into shadow registers x0, y0, sc, en.
  - Mid-frame input changes have no effect until the next frame.
- Box test, stage 0, combinational on current DrawX/DrawY:
  - in_x = DrawX >= x0 && DrawX < x0 + (SPRITE_W << sc).
  - in_y likewise for DrawY with SPRITE_H.
  - Compute in 11+ bits so x0 + extent never wraps; a sprite overhanging the right or bottom edge is clipped, with no wrap to the left or top.
- Row tracking:
  - prev_y register holds the previous DrawY.
  - row_base is cleared at the frame latch.
  - When DrawY != prev_y && DrawY > y0 && in_y && ((DrawY - y0) & ((1<<sc)-1)) == 0, row_base += SPRITE_W.
- Column: col = (DrawX - x0) >> sc.
- Address: on each vga_clk edge, rom_address <= in_x && in_y ? row_base + col : 0.
- Alignment pipeline:
  - Hit flag, blank and bg RGB are delayed 1 + ROM_LATENCY cycles so they align with rom_q.
  - pal_index = rom_q.
- Output stage, registered:
  - blank_d == 0: RGB = 0, sprite_hit = 0.
  - Else, if en && hit_d && rom_q != TRANSPARENT_IDX: RGB = pal_*, sprite_hit = 1.
  - Otherwise RGB = bg_*_d, sprite_hit = 0.
- Latency: 2 + ROM_LATENCY vga_clk cycles from DrawX/DrawY/bg presentation to red/green/blue.
- Boundaries:
  - sc=3 with 130-wide sprite: extent 1040, fully clipped past 639.
  - x0 >= 640: never hits.
  - Reset mid-frame: output stays background/black until the next frame latch restores the shadow registers (shadow=0 with en=0 means pass-through).

Optional Feature:
- Macro: SPRITE_LAYER_MIRROR_EN.
- Defined: adds input port mirror_x (1 bit), latched at the frame latch. When set, col = SPRITE_W - 1 - ((DrawX - x0) >> sc), giving a horizontal flip.
- Undefined: no port, no flip logic.

Test Plan:
- Frame latch, then unscaled draw: sprite_x=100, sprite_y=50, scale=0, layer_en=1, ROM[i]=i%16 -> at DrawX=100, DrawY=50, rom_address=0 and red=pal(0)=bg (transparent). At DrawX=101, DrawY=51: rom_address=131, output appears 3 cycles later with ROM_LATENCY=1.
- Scaling: scale=2 at position (0,0) -> DrawX 0..3 all give address 0, DrawX=4 gives 1. DrawY=4 row gives row_base=130. Last hit pixel DrawX=519, DrawY=199.
- Transparency and bg: bg=4'hA on all channels, texel index 0 -> output A,A,A and sprite_hit=0. Texel index 5 -> pal values and sprite_hit=1.
- Clipping: sprite_x=600, scale=0 -> hits only for DrawX 600..639, no hits at DrawX 0..89 of the same rows.
- Tear-free latch and blank: change sprite_x from 100 to 200 at DrawY=240 -> the sprite stays at 100 until next frame. blank=0 -> RGB=0.
- Async reset: assert reset mid-line -> outputs 0 immediately without a clock edge. After release, with layer_en=0 latched, output equals bg.
